stb_dcache_arbiter: RTL and testbench

Shares the single data-cache port between LSU load requests and store-buffer (STB) drain writes. Sits between the STB datapath/controller and the data cache. Load requests have priority by default. The STB wins when it is nearly full, starved, fenced, or holding a store to the same address as the pending load. Exactly one cache transaction is outstanding at a time; the grant is held until the cache acknowledges.

---
 rtl/stb_pkg.sv | 16 +
 rtl/stb_arb_starve_cnt.sv | 32 +++
 rtl/stb_dcache_arbiter.sv | 126 ++++++++++++
 tb/tb_stb_dcache_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stb_pkg.sv
// Shared types and default widths for the store-buffer / data-cache arbiter.
package stb_pkg;

  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_CNT_WIDTH    = 4;
  localparam int DEF_HIGH_WM      = 6;
  localparam int DEF_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LD_BUSY = 2'b01,
    ST_BUSY = 2'b10
  } arb_state_t;

endpackage

// File: rtl/stb_arb_starve_cnt.sv
// Saturating wait counter; sat_o tells the arbiter the STB drain has waited long enough.
module stb_arb_starve_cnt
  import stb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;

  // Clear has priority so a drain grant restarts the wait even if inc is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign sat_o = (cnt == LIMIT);

endmodule

// File: rtl/stb_dcache_arbiter.sv
// Arbitrates the single data-cache port between LSU loads and STB drain writes.
module stb_dcache_arbiter
  import stb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int HIGH_WM      = DEF_HIGH_WM,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_req_i,
  input  logic [ADDR_WIDTH-1:0]   ld_addr_i,
  input  logic                    ld_hazard_i,
  output logic                    ld_ack_o,
  output logic [DATA_WIDTH-1:0]   ld_rdata_o,
  input  logic                    stb_req_i,
  input  logic [ADDR_WIDTH-1:0]   stb_addr_i,
  input  logic [DATA_WIDTH-1:0]   stb_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] stb_sel_byte_i,
  input  logic [CNT_WIDTH-1:0]    stb_count_i,
  output logic                    stb_ack_o,
  input  logic                    fence_i,
  output logic                    fence_done_o,
  output logic                    dcache_req_o,
  output logic                    dcache_w_en_o,
  output logic [ADDR_WIDTH-1:0]   dcache_addr_o,
  output logic [DATA_WIDTH-1:0]   dcache_wdata_o,
  output logic [DATA_WIDTH/8-1:0] dcache_sel_byte_o,
  input  logic                    dcache_ack_i,
  input  logic [DATA_WIDTH-1:0]   dcache_rdata_i
);

  localparam logic [CNT_WIDTH-1:0] HIGH_WM_C = CNT_WIDTH'(HIGH_WM);

  arb_state_t state, state_next;
  logic       fence_pending;
  logic       starve_sat;
  logic       st_prio;
  logic       ld_grant;
  logic       st_grant;

  stb_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stb_req_i && (state != ST_BUSY)),
    .clr  (!stb_req_i || st_grant),
    .sat_o(starve_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fence uses the registered flag, so a fence arriving with a load grant does not block that grant.
  always_comb begin
    state_next = state;
    ld_grant   = 1'b0;
    st_grant   = 1'b0;
    st_prio    = stb_req_i && (fence_pending || (ld_req_i && ld_hazard_i) ||
                               (stb_count_i >= HIGH_WM_C) || starve_sat);
    case (state)
      IDLE: begin
        if (st_prio) begin
          st_grant = 1'b1;
        end else if (ld_req_i && !ld_hazard_i && !fence_pending) begin
          ld_grant = 1'b1;
        end else if (stb_req_i) begin
          st_grant = 1'b1;
        end
        if (st_grant) begin
          state_next = ST_BUSY;
        end else if (ld_grant) begin
          state_next = LD_BUSY;
        end
      end
      LD_BUSY: if (dcache_ack_i) state_next = IDLE;
      ST_BUSY: if (dcache_ack_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fence_pending <= 1'b0;
    end else if (fence_done_o) begin
      fence_pending <= 1'b0;
    end else if (fence_i) begin
      fence_pending <= 1'b1;
    end
  end

  // Request fields are captured at the grant edge and held for the whole busy period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dcache_w_en_o     <= 1'b0;
      dcache_addr_o     <= '0;
      dcache_wdata_o    <= '0;
      dcache_sel_byte_o <= '0;
    end else if (st_grant) begin
      dcache_w_en_o     <= 1'b1;
      dcache_addr_o     <= stb_addr_i;
      dcache_wdata_o    <= stb_wdata_i;
      dcache_sel_byte_o <= stb_sel_byte_i;
    end else if (ld_grant) begin
      dcache_w_en_o     <= 1'b0;
      dcache_addr_o     <= ld_addr_i;
      dcache_wdata_o    <= '0;
      dcache_sel_byte_o <= '0;
    end
  end

  assign dcache_req_o = (state != IDLE);
  assign ld_ack_o     = (state == LD_BUSY) && dcache_ack_i;
  assign ld_rdata_o   = ld_ack_o ? dcache_rdata_i : '0;
  assign stb_ack_o    = (state == ST_BUSY) && dcache_ack_i;
  assign fence_done_o = (state == IDLE) && fence_pending && !stb_req_i;

endmodule

// File: tb/tb_stb_dcache_arbiter.sv
// Directed self-checking bench for stb_dcache_arbiter with hand-computed expectations.
module tb_stb_dcache_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_req_i, ld_hazard_i, ld_ack_o;
  logic [31:0] ld_addr_i, ld_rdata_o;
  logic        stb_req_i, stb_ack_o;
  logic [31:0] stb_addr_i, stb_wdata_i;
  logic [3:0]  stb_sel_byte_i, stb_count_i;
  logic        fence_i, fence_done_o;
  logic        dcache_req_o, dcache_w_en_o, dcache_ack_i;
  logic [31:0] dcache_addr_o, dcache_wdata_o, dcache_rdata_i;
  logic [3:0]  dcache_sel_byte_o;

  int passed = 0;
  int total  = 0;
  int loads, stores;
  logic store_seen;

  stb_dcache_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_hazard_i(ld_hazard_i),
    .ld_ack_o(ld_ack_o), .ld_rdata_o(ld_rdata_o),
    .stb_req_i(stb_req_i), .stb_addr_i(stb_addr_i), .stb_wdata_i(stb_wdata_i),
    .stb_sel_byte_i(stb_sel_byte_i), .stb_count_i(stb_count_i), .stb_ack_o(stb_ack_o),
    .fence_i(fence_i), .fence_done_o(fence_done_o),
    .dcache_req_o(dcache_req_o), .dcache_w_en_o(dcache_w_en_o),
    .dcache_addr_o(dcache_addr_o), .dcache_wdata_o(dcache_wdata_o),
    .dcache_sel_byte_o(dcache_sel_byte_o), .dcache_ack_i(dcache_ack_i),
    .dcache_rdata_i(dcache_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic ld_req, input logic [31:0] ld_addr, input logic hazard,
                               input logic stb_req, input logic [31:0] stb_addr,
                               input logic [31:0] wdata, input logic [3:0] sel,
                               input logic [3:0] count, input logic fence);
    ld_req_i = ld_req; ld_addr_i = ld_addr; ld_hazard_i = hazard;
    stb_req_i = stb_req; stb_addr_i = stb_addr; stb_wdata_i = wdata;
    stb_sel_byte_i = sel; stb_count_i = count; fence_i = fence;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ack the transaction in flight for one cycle, returning just after the edge it ends on.
  task automatic serveAck(input logic [31:0] rdata);
    dcache_ack_i = 1'b1;
    dcache_rdata_i = rdata;
    step();
    dcache_ack_i = 1'b0;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    dcache_ack_i = 1'b1;
    dcache_rdata_i = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    checkOutput("rst_req", dcache_req_o, 0);
    checkOutput("rst_w_en", dcache_w_en_o, 0);
    checkOutput("rst_addr", dcache_addr_o, 0);
    checkOutput("rst_ld_ack", ld_ack_o, 0);
    checkOutput("rst_ld_rdata", ld_rdata_o, 0);
    checkOutput("rst_stb_ack", stb_ack_o, 0);
    checkOutput("rst_fence_done", fence_done_o, 0);
    step();
    rst_n = 1'b1;
    dcache_ack_i = 1'b0;
    dcache_rdata_i = 0;

    // Load only
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("ld_not_yet", dcache_req_o, 0);
    step();
    @(negedge clk);
    checkOutput("ld_req", dcache_req_o, 1);
    checkOutput("ld_addr", dcache_addr_o, 32'h100);
    checkOutput("ld_w_en", dcache_w_en_o, 0);
    checkOutput("ld_sel", dcache_sel_byte_o, 0);
    step();
    @(negedge clk);
    checkOutput("ld_hold", dcache_req_o, 1);
    step();
    dcache_ack_i = 1'b1;
    dcache_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("ld_ack", ld_ack_o, 1);
    checkOutput("ld_rdata", ld_rdata_o, 32'hDEAD_BEEF);
    checkOutput("ld_no_stb_ack", stb_ack_o, 0);
    step();
    dcache_ack_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("ld_done_req", dcache_req_o, 0);
    checkOutput("ld_done_ack", ld_ack_o, 0);
    step();

    // Contention + starvation: loads at cycles 0,2,4,6, counter saturates, store at cycle 8
    applyStimulus(1, 32'h200, 0, 1, 32'h300, 32'hCAFE_F00D, 4'b0011, 2, 0);
    loads = 0;
    store_seen = 1'b0;
    for (int i = 0; i < 40 && !store_seen; i++) begin
      @(negedge clk);
      if (dcache_req_o) begin
        if (dcache_w_en_o) begin
          store_seen = 1'b1;
          checkOutput("starve_st_addr", dcache_addr_o, 32'h300);
          checkOutput("starve_st_wdata", dcache_wdata_o, 32'hCAFE_F00D);
          checkOutput("starve_st_sel", dcache_sel_byte_o, 4'b0011);
          dcache_ack_i = 1'b1;
          #1 checkOutput("starve_stb_ack", stb_ack_o, 1);
        end else begin
          if (loads == 0) checkOutput("contention_ld_addr", dcache_addr_o, 32'h200);
          loads++;
          dcache_ack_i = 1'b1;
        end
      end
      step();
      dcache_ack_i = 1'b0;
    end
    checkOutput("starve_store_seen", store_seen, 1);
    checkOutput("starve_load_count", loads, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Watermark at 6 drains, at 5 the load wins
    applyStimulus(1, 32'h500, 0, 1, 32'h600, 32'h1234_5678, 4'hF, 6, 0);
    step();
    @(negedge clk);
    checkOutput("wm6_w_en", dcache_w_en_o, 1);
    checkOutput("wm6_addr", dcache_addr_o, 32'h600);
    step();
    serveAck(0);
    applyStimulus(1, 32'h500, 0, 1, 32'h600, 32'h1234_5678, 4'hF, 5, 0);
    step();
    @(negedge clk);
    checkOutput("wm5_req", dcache_req_o, 1);
    checkOutput("wm5_w_en", dcache_w_en_o, 0);
    checkOutput("wm5_addr", dcache_addr_o, 32'h500);
    serveAck(0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Inconsistent hazard with empty STB: no grant
    applyStimulus(1, 32'h700, 1, 0, 0, 0, 0, 0, 0);
    step();
    step();
    @(negedge clk);
    checkOutput("hazard_empty_no_grant", dcache_req_o, 0);
    step();

    // Hazard: store drains first, load follows
    applyStimulus(1, 32'h400, 1, 1, 32'h400, 32'hAAAA_5555, 4'b1100, 1, 0);
    step();
    @(negedge clk);
    checkOutput("hazard_st_first", dcache_w_en_o, 1);
    checkOutput("hazard_st_addr", dcache_addr_o, 32'h400);
    serveAck(0);
    applyStimulus(1, 32'h400, 0, 0, 0, 0, 0, 0, 0);
    step();
    @(negedge clk);
    checkOutput("hazard_ld_req", dcache_req_o, 1);
    checkOutput("hazard_ld_w_en", dcache_w_en_o, 0);
    serveAck(32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Fence with load grant in the same cycle, then three stores, then fence_done
    applyStimulus(1, 32'h800, 0, 1, 32'h900, 32'h0BAD_CAFE, 4'h1, 3, 1);
    step();
    fence_i = 1'b0;
    @(negedge clk);
    checkOutput("fence_same_cycle_ld", dcache_req_o && !dcache_w_en_o, 1);
    serveAck(0);
    loads = 0;
    stores = 0;
    for (int i = 0; i < 30 && stores < 3; i++) begin
      @(negedge clk);
      if (dcache_req_o) begin
        if (dcache_w_en_o) stores++;
        else loads++;
        dcache_ack_i = 1'b1;
      end
      step();
      dcache_ack_i = 1'b0;
      if (stores == 3) stb_req_i = 1'b0;
      else stb_count_i = 4'(3 - stores);
    end
    checkOutput("fence_store_count", stores, 3);
    checkOutput("fence_no_loads", loads, 0);
    @(negedge clk);
    checkOutput("fence_done_pulse", fence_done_o, 1);
    checkOutput("fence_no_ld_grant", dcache_req_o, 0);
    step();
    @(negedge clk);
    checkOutput("fence_done_one_cycle", fence_done_o, 0);
    checkOutput("fence_ld_not_yet", dcache_req_o, 0);
    step();
    @(negedge clk);
    checkOutput("fence_ld_after", dcache_req_o && !dcache_w_en_o, 1);
    serveAck(0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Reset during ST_BUSY, late ack ignored
    applyStimulus(0, 0, 0, 1, 32'hA00, 32'hFEED_FACE, 4'h3, 1, 0);
    step();
    @(negedge clk);
    checkOutput("rst_mid_busy", dcache_req_o && dcache_w_en_o, 1);
    step();
    rst_n = 1'b0;
    stb_req_i = 1'b0;
    step();
    @(negedge clk);
    checkOutput("rst_mid_req", dcache_req_o, 0);
    checkOutput("rst_mid_w_en", dcache_w_en_o, 0);
    checkOutput("rst_mid_addr", dcache_addr_o, 0);
    checkOutput("rst_mid_wdata", dcache_wdata_o, 0);
    checkOutput("rst_mid_sel", dcache_sel_byte_o, 0);
    dcache_ack_i = 1'b1;
    #1;
    checkOutput("rst_late_stb_ack", stb_ack_o, 0);
    checkOutput("rst_late_ld_ack", ld_ack_o, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_late_ack", stb_ack_o, 0);
    dcache_ack_i = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
